// File: rtl/sram2p_pipe_if.sv
// Bus bundle for sram2p_pipe: write port, read port, global advance and read result.
// The DUT takes the slave modport; whoever drives requests uses master.
interface sram2p_pipe_if #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 72,
   parameter int BYTEW  = 8
);
   localparam int NBYTES = DWIDTH / BYTEW;

   logic              mem_enable;
   logic              write_enable;
   logic [AWIDTH-1:0] write_address;
   logic [DWIDTH-1:0] write_data;
   logic [NBYTES-1:0] write_strb;
   logic              read_enable;
   logic [AWIDTH-1:0] read_address;
   logic              read_valid;
   logic [DWIDTH-1:0] read_data;

   modport master (
      output mem_enable, write_enable, write_address, write_data, write_strb,
      output read_enable, read_address,
      input  read_valid, read_data
   );

   modport slave (
      input  mem_enable, write_enable, write_address, write_data, write_strb,
      input  read_enable, read_address,
      output read_valid, read_data
   );
endinterface

// File: rtl/sram2p_pipe.sv
// Simple dual-port RAM with byte strobes, a stallable read pipeline of 1+NBPIPE stages
// and a travelling read-valid. Optional same-cycle write-to-read forwarding: SRAM2P_RAW_FWD_EN.
module sram2p_pipe #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 72,
   parameter int BYTEW  = 8,
   parameter int NBPIPE = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   sram2p_pipe_if.slave bus
);
   localparam int NBYTES = DWIDTH / BYTEW;
   localparam int DEPTH  = 1 << AWIDTH;

   logic [DWIDTH-1:0]             r_mem [DEPTH];
   logic [NBPIPE:0]               r_vld_pipe;
   logic [NBPIPE:0][DWIDTH-1:0]   r_dat_pipe;
   logic [DWIDTH-1:0]             w_arr_data;

   // Array is never reset so contents survive rst_n; writes are blocked while it is low.
   always_ff @(posedge clk) begin
      if (rst_n && bus.mem_enable && bus.write_enable) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.write_strb[i])
               r_mem[bus.write_address][i*BYTEW +: BYTEW] <= bus.write_data[i*BYTEW +: BYTEW];
         end
      end
   end

   // Stage 0 is the array register; it reads before the same-edge write lands (read-first).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_dat_pipe <= '0;
      end else if (bus.mem_enable) begin
         r_vld_pipe[0] <= bus.read_enable;
         r_dat_pipe[0] <= r_mem[bus.read_address];
         for (int k = 1; k <= NBPIPE; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_dat_pipe[k] <= (k == 1) ? w_arr_data : r_dat_pipe[k-1];
         end
      end
   end

`ifdef SRAM2P_RAW_FWD_EN
   logic              w_hit;
   logic [NBYTES-1:0] r_fwd_mask;
   logic [DWIDTH-1:0] r_fwd_data;

   assign w_hit = bus.write_enable && bus.read_enable &&
                  (bus.write_address == bus.read_address);

   // Lanes being written on the colliding edge override the stale array read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_mask <= '0;
         r_fwd_data <= '0;
      end else if (bus.mem_enable) begin
         r_fwd_mask <= w_hit ? bus.write_strb : '0;
         r_fwd_data <= bus.write_data;
      end
   end

   always_comb begin
      w_arr_data = r_dat_pipe[0];
      for (int i = 0; i < NBYTES; i++) begin
         if (r_fwd_mask[i])
            w_arr_data[i*BYTEW +: BYTEW] = r_fwd_data[i*BYTEW +: BYTEW];
      end
   end
`else
   assign w_arr_data = r_dat_pipe[0];
`endif

   generate
      if (NBPIPE == 0) begin : g_nopipe
         assign bus.read_data = w_arr_data;
      end else begin : g_pipe
         assign bus.read_data = r_dat_pipe[NBPIPE];
      end
   endgenerate

   assign bus.read_valid = r_vld_pipe[NBPIPE];
endmodule

// File: doc/sram2p_pipe.md
Name: sram2p_pipe

Overview:
- Parametrised simple dual-port RAM: one write port and one read port, with a configurable read-output pipeline.
- Adds per-byte write strobes, a read-request valid that travels down the pipeline, and a global stall through mem_enable.
- Optional same-cycle write-to-read forwarding.
- Used as the history and hash-table storage primitive in the match pipelines. Maps to ultra RAM plus fabric registers.

Parameters:
- AWIDTH, 12, address width; depth = 2^AWIDTH entries.
- DWIDTH, 72, data width in bits. Must be an integer multiple of BYTEW.
- BYTEW, 8, bits per write-strobe lane. NBYTES = DWIDTH/BYTEW (default 9).
- NBPIPE, 3, extra output register stages after the array register. Range 0..8.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- mem_enable, input, 1, global advance. 0 freezes writes, read issue and every pipeline stage.
- write_enable, input, 1, write request, qualified by mem_enable.
- write_address, input, AWIDTH, write address.
- write_data, input, DWIDTH, write data.
- write_strb, input, NBYTES, lane i writes bits [i*BYTEW +: BYTEW].
- read_enable, input, 1, read request, qualified by mem_enable.
- read_address, input, AWIDTH, read address.
- read_valid, output, 1, read_data holds the result of a request.
- read_data, output, DWIDTH, read result.

Behaviour:
- An "advance cycle" is a rising clk edge with mem_enable=1 and rst_n=1. Nothing in the block changes state on other edges.
- Write: on an advance cycle with write_enable=1, mem[write_address] lanes with write_strb[i]=1 take write_data. Other lanes are unchanged. write_strb all-zero is a no-op.
- Read issue: on an advance cycle with read_enable=1, the array register captures mem[read_address] and the valid bit is set to 1. With read_enable=0 the valid bit is set to 0, and the data register may still load; its value is don't-care.
- Pipeline: stage k+1 loads stage k, data and valid together, on every advance cycle. Total latency is 1+NBPIPE advance cycles (default 4).
- NBPIPE=0: outputs are driven directly from the array register.
- Stall: mem_enable=0 holds all stages and outputs. Stall cycles do not count toward latency. A request is never dropped or duplicated across a stall.
- Ordering: a read issued in cycle t observes all writes from advance cycles before t.
- Same-cycle same-address collision without the optional feature: read-first, so the old data is returned.
- Reset (rst_n=0, asynchronous):
  - All valid bits clear to 0, so read_valid=0 immediately.
  - All pipeline data registers clear to 0, so read_data=0.
  - Array contents are not reset and are preserved across reset.
  - Writes presented while rst_n=0 are ignored.
  - Reset mid-flight discards in-flight reads with no late read_valid.
- Address wrap: none. The full 2^AWIDTH range is addressable and every address is legal.
- Back-to-back reads sustain one result per advance cycle. Reads and writes proceed simultaneously with no throughput penalty.

Optional Feature:
- Macro SRAM2P_RAW_FWD_EN.
- Defined: on a same-cycle write and read to the same address, the captured read data is merged per lane. Lanes with write_strb=1 take write_data; the others take old mem contents (write-first per lane). Uses one address comparator plus a registered NBYTES-wide lane mask and DWIDTH data bypass at the array-register stage. Latency is unchanged.
- Undefined: no comparator. Collisions return old data.

Test Plan:
- Reset, then write 0x0A5 at address 0x010 with all strobes, then read 0x010 with mem_enable held at 1 -> read_valid=1 with read_data=0x0A5 exactly 4 cycles after issue. read_valid=0 on all other cycles.
- Preload 0x010 with all bytes 0xFF. Write strb=9'h001 with data 0x...00 -> a later read returns 0xFF_FFFF_FFFF_FFFF_FF00.
- Issue a read, then drop mem_enable for 5 cycles after its 2nd advance -> read_valid appears on the 4th advance cycle and outputs hold during the stall.
- Same-cycle write 0x123 and read of the same address holding 0x777 -> returns 0x777 without the macro, 0x123 with SRAM2P_RAW_FWD_EN.
- Issue 3 reads, assert rst_n=0 after 2 cycles -> read_valid=0 and read_data=0 at once with no later valid. Array data written before reset reads back unchanged after reset.
- Sweep NBPIPE=0 and NBPIPE=8 with a 64-read burst at consecutive addresses -> latencies of 1 and 9, one result per cycle, data in order.
